// File: rtl/warp_scheduler_if.sv
// -----------------------------------------------------------------------------
// warp_scheduler_if
// Purpose : bundles the launch, issue, retire and LSU-completion signals of the
//           warp scheduler.
// Modports: master - the scheduler (drives issue_*, busy, kernel_done)
//           slave  - the surrounding controller/LSU (drives everything else)
// Signals : start/start_pc/warp_mask   kernel launch
//           issue_valid/warp/pc/ready  issue offer handshake
//           retire_*                   instruction completion report
//           mem_done_valid/warp        LSU completion for a waiting warp
//           busy/kernel_done           kernel status
// -----------------------------------------------------------------------------
interface warp_scheduler_if #(
   parameter int NUM_WARPS = 4,
   parameter int PC_WIDTH  = 8
);
   localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

   logic                 start;
   logic [PC_WIDTH-1:0]  start_pc;
   logic [NUM_WARPS-1:0] warp_mask;

   logic                 issue_valid;
   logic [WID_W-1:0]     issue_warp;
   logic [PC_WIDTH-1:0]  issue_pc;
   logic                 issue_ready;

   logic                 retire_valid;
   logic [WID_W-1:0]     retire_warp;
   logic [PC_WIDTH-1:0]  retire_next_pc;
   logic                 retire_mem;
   logic                 retire_halt;

   logic                 mem_done_valid;
   logic [WID_W-1:0]     mem_done_warp;

   logic                 busy;
   logic                 kernel_done;

   modport master (
      input  start, start_pc, warp_mask, issue_ready,
             retire_valid, retire_warp, retire_next_pc, retire_mem, retire_halt,
             mem_done_valid, mem_done_warp,
      output issue_valid, issue_warp, issue_pc, busy, kernel_done
   );

   modport slave (
      output start, start_pc, warp_mask, issue_ready,
             retire_valid, retire_warp, retire_next_pc, retire_mem, retire_halt,
             mem_done_valid, mem_done_warp,
      input  issue_valid, issue_warp, issue_pc, busy, kernel_done
   );
endinterface

// File: rtl/warp_scheduler.sv
// -----------------------------------------------------------------------------
// warp_scheduler
// Purpose : round-robin issue scheduler for NUM_WARPS warps, each with its own
//           PC and a state of OFF/READY/BUSY/WAIT_MEM/DONE. A top FSM
//           (IDLE/RUN/FINISH) tracks the kernel.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous, active-high
//           bus   - warp_scheduler_if.master (launch, issue, retire, mem_done,
//                   busy/kernel_done)
//           stall_cycles - 16-bit saturating count of RUN cycles without an
//                   issue handshake; present only with WARP_SCHED_STALL_CNT_EN
// Option  : `define WARP_SCHED_STALL_CNT_EN to add the stall counter.
// -----------------------------------------------------------------------------
module warp_scheduler #(
   parameter int NUM_WARPS = 4,
   parameter int PC_WIDTH  = 8
) (
   input  logic             clk,
   input  logic             reset,
   warp_scheduler_if.master bus
`ifdef WARP_SCHED_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cycles
`endif
);
   localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
   typedef enum logic [2:0] {W_OFF, W_READY, W_BUSY, W_WAIT_MEM, W_DONE} wstate_t;

   state_t              r_state;
   wstate_t             r_wstate [NUM_WARPS];
   logic [PC_WIDTH-1:0] r_pc     [NUM_WARPS];
   logic [WID_W-1:0]    r_last;
   logic                r_issue_valid;
   logic [WID_W-1:0]    r_issue_warp;
   logic [PC_WIDTH-1:0] r_issue_pc;
   logic                r_busy;
   logic                r_kernel_done;
`ifdef WARP_SCHED_STALL_CNT_EN
   logic [15:0]         r_stall;
`endif

   wstate_t             w_wnext  [NUM_WARPS];
   logic [PC_WIDTH-1:0] w_pcnext [NUM_WARPS];
   logic                w_fire;
   logic                w_start_ok;
   logic                w_all_done;
   logic                w_sel_valid;
   logic [WID_W-1:0]    w_sel;
   logic [WID_W-1:0]    w_base;
   logic [WID_W-1:0]    w_idx;

   assign w_fire     = r_issue_valid && bus.issue_ready;
   assign w_start_ok = bus.start && (bus.warp_mask != '0) && (r_state != S_RUN);
   // the warp being accepted this cycle counts as the last issued one
   assign w_base     = w_fire ? r_issue_warp : r_last;

   // Next per-warp state: retire, mem_done and issue for distinct warps all apply.
   always_comb begin : warp_next
      w_all_done = 1'b1;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         w_wnext[w]  = r_wstate[w];
         w_pcnext[w] = r_pc[w];
         if (bus.retire_valid && (bus.retire_warp == WID_W'(w)) && (r_wstate[w] == W_BUSY)) begin
            if (bus.retire_halt) begin
               w_wnext[w] = W_DONE;
            end else begin
               w_wnext[w]  = bus.retire_mem ? W_WAIT_MEM : W_READY;
               w_pcnext[w] = bus.retire_next_pc;
            end
         end
         if (bus.mem_done_valid && (bus.mem_done_warp == WID_W'(w)) && (r_wstate[w] == W_WAIT_MEM))
            w_wnext[w] = W_READY;
         if (w_fire && (r_issue_warp == WID_W'(w)))
            w_wnext[w] = W_BUSY;
         if ((w_wnext[w] != W_OFF) && (w_wnext[w] != W_DONE))
            w_all_done = 1'b0;
      end
   end

   // Round-robin pick from the registered READY set; the warp accepted this
   // cycle is excluded, so a warp made READY at edge N is first offered at N+1.
   always_comb begin : rr_select
      w_sel_valid = 1'b0;
      w_sel       = '0;
      w_idx       = '0;
      for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
         w_idx = WID_W'((32'(w_base) + i) % 32'(NUM_WARPS));
         if (!w_sel_valid && (r_wstate[w_idx] == W_READY) && !(w_fire && (r_issue_warp == w_idx))) begin
            w_sel_valid = 1'b1;
            w_sel       = w_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            r_wstate[w] <= W_OFF;
            r_pc[w]     <= '0;
         end
         r_last        <= WID_W'(NUM_WARPS - 1);
         r_issue_valid <= 1'b0;
         r_issue_warp  <= '0;
         r_issue_pc    <= '0;
         r_busy        <= 1'b0;
         r_kernel_done <= 1'b0;
`ifdef WARP_SCHED_STALL_CNT_EN
         r_stall       <= '0;
`endif
      end else if (w_start_ok) begin
         r_state       <= S_RUN;
         for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            r_wstate[w] <= bus.warp_mask[w] ? W_READY : W_OFF;
            if (bus.warp_mask[w])
               r_pc[w] <= bus.start_pc;
         end
         r_last        <= WID_W'(NUM_WARPS - 1);
         r_issue_valid <= 1'b0;
         r_busy        <= 1'b1;
         r_kernel_done <= 1'b0;
`ifdef WARP_SCHED_STALL_CNT_EN
         r_stall       <= '0;
`endif
      end else if (r_state == S_RUN) begin
         r_wstate <= w_wnext;
         r_pc     <= w_pcnext;
         if (w_fire)
            r_last <= r_issue_warp;
         // offer is held while stalled; otherwise reloaded (or dropped) each cycle
         if (!r_issue_valid || bus.issue_ready) begin
            r_issue_valid <= w_sel_valid;
            if (w_sel_valid) begin
               r_issue_warp <= w_sel;
               r_issue_pc   <= r_pc[w_sel];
            end
         end
         if (w_all_done) begin
            r_state       <= S_FINISH;
            r_issue_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_kernel_done <= 1'b1;
         end
`ifdef WARP_SCHED_STALL_CNT_EN
         if (!w_fire && (r_stall != '1))
            r_stall <= r_stall + 16'd1;
`endif
      end
   end

   assign bus.issue_valid = r_issue_valid;
   assign bus.issue_warp  = r_issue_warp;
   assign bus.issue_pc    = r_issue_pc;
   assign bus.busy        = r_busy;
   assign bus.kernel_done = r_kernel_done;
`ifdef WARP_SCHED_STALL_CNT_EN
   assign stall_cycles    = r_stall;
`endif
endmodule

// File: tb/tb_warp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_warp_scheduler
// Purpose : self-checking bench for warp_scheduler (NUM_WARPS=4, PC_WIDTH=8).
//           Launch vectors come from a table; issue streams are checked against
//           a queue of expected {warp, pc} filled when a kernel is launched and
//           popped on every issue handshake. A responder retires each accepted
//           instruction the following cycle with next_pc = pc + 1.
// Option  : WARP_SCHED_STALL_CNT_EN enables the stall_cycles checks.
// -----------------------------------------------------------------------------
module tb_warp_scheduler;
   logic clk = 1'b0;
   logic reset;
`ifdef WARP_SCHED_STALL_CNT_EN
   logic [15:0] stall;
   logic [15:0] s_ref;
`endif

   always #5 clk = ~clk;

   warp_scheduler_if #(.NUM_WARPS(4), .PC_WIDTH(8)) bus ();

   warp_scheduler #(.NUM_WARPS(4), .PC_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus)
`ifdef WARP_SCHED_STALL_CNT_EN
      ,
      .stall_cycles (stall)
`endif
   );

   typedef struct {
      logic [3:0] mask;
      logic [7:0] pc;
      logic       exp_busy;
      logic       exp_valid;
      logic [1:0] exp_warp;
      logic [7:0] exp_pc;
   } vec_t;

   typedef struct packed {
      logic [1:0] w;
      logic [7:0] pc;
   } exp_t;

   vec_t     vecs [5];
   exp_t     sb [$];
   int       checks   = 0;
   int       failures = 0;
   bit [3:0] mem_once;
   bit [3:0] halt_on;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.start          = 1'b0;
      bus.start_pc       = '0;
      bus.warp_mask      = '0;
      bus.issue_ready    = 1'b0;
      bus.retire_valid   = 1'b0;
      bus.retire_warp    = '0;
      bus.retire_next_pc = '0;
      bus.retire_mem     = 1'b0;
      bus.retire_halt    = 1'b0;
      bus.mem_done_valid = 1'b0;
      bus.mem_done_warp  = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      clear_inputs();
      mem_once = '0;
      halt_on  = '0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // start pulse for one cycle; returns 1 time unit after the accepting edge
   task automatic launch(input logic [3:0] mask, input logic [7:0] pc);
      @(posedge clk); #1;
      bus.warp_mask = mask;
      bus.start_pc  = pc;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start     = 1'b0;
   endtask

   task automatic respond(input bit hs, input logic [1:0] w, input logic [7:0] p);
      bus.retire_valid   = hs;
      bus.retire_warp    = w;
      bus.retire_next_pc = p + 8'd1;
      bus.retire_mem     = hs && mem_once[w];
      bus.retire_halt    = hs && halt_on[w];
      if (hs) mem_once[w] = 1'b0;
   endtask

   // accept offers until the scoreboard drains or the cycle budget runs out
   task automatic run(input int budget, input string name);
      int         n = 0;
      bit         hs;
      logic [1:0] w;
      logic [7:0] p;
      exp_t       e;
      bus.issue_ready = 1'b1;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         hs = bus.issue_valid && bus.issue_ready;
         w  = bus.issue_warp;
         p  = bus.issue_pc;
         if (hs) begin
            e = sb.pop_front();
            check({name, "_warp"}, 32'(w), 32'(e.w));
            check({name, "_pc"},   32'(p), 32'(e.pc));
         end
         @(posedge clk); #1;
         respond(hs, w, p);
         if (sb.size() == 0) bus.issue_ready = 1'b0;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: %0d issues outstanding after %0d cycles, required 0", name, sb.size(), budget);
         sb.delete();
      end
      bus.issue_ready = 1'b0;
      @(posedge clk); #1;
      respond(1'b0, 2'd0, 8'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      vecs[0] = '{4'b1111, 8'h10, 1'b1, 1'b1, 2'd0, 8'h10};
      vecs[1] = '{4'b0101, 8'h20, 1'b1, 1'b1, 2'd0, 8'h20};
      vecs[2] = '{4'b0100, 8'h33, 1'b1, 1'b1, 2'd2, 8'h33};
      vecs[3] = '{4'b1000, 8'hA5, 1'b1, 1'b1, 2'd3, 8'hA5};
      vecs[4] = '{4'b0000, 8'h44, 1'b0, 1'b0, 2'd0, 8'h00};
      mem_once = '0;
      halt_on  = '0;
      clear_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(bus.issue_valid), 32'd0);
      check("rst_warp",  32'(bus.issue_warp),  32'd0);
      check("rst_pc",    32'(bus.issue_pc),    32'd0);
      check("rst_busy",  32'(bus.busy),        32'd0);
      check("rst_done",  32'(bus.kernel_done), 32'd0);
`ifdef WARP_SCHED_STALL_CNT_EN
      check("rst_stall", 32'(stall), 32'd0);
`endif
      reset = 1'b0;

      // launch table: first offer appears one cycle after the start edge
      for (int i = 0; i < 5; i++) begin
         do_reset();
         launch(vecs[i].mask, vecs[i].pc);
         @(negedge clk);
         check($sformatf("v%0d_busy", i),   32'(bus.busy),        32'(vecs[i].exp_busy));
         check($sformatf("v%0d_early", i),  32'(bus.issue_valid), 32'd0);
         @(negedge clk);
         check($sformatf("v%0d_valid", i),  32'(bus.issue_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_done", i),   32'(bus.kernel_done), 32'd0);
         if (vecs[i].exp_valid) begin
            check($sformatf("v%0d_warp", i), 32'(bus.issue_warp), 32'(vecs[i].exp_warp));
            check($sformatf("v%0d_pc", i),   32'(bus.issue_pc),   32'(vecs[i].exp_pc));
         end
      end

      // all four warps, back-to-back issue with immediate retires
      do_reset();
      for (int k = 0; k < 12; k++) begin
         e.w  = 2'(k % 4);
         e.pc = 8'(8'h10 + k / 4);
         sb.push_back(e);
      end
      launch(4'b1111, 8'h10);
      run(60, "rr");

      // warp 0 parks in WAIT_MEM; only warp 2 is offered until mem_done
      do_reset();
      mem_once = 4'b0001;
      sb.push_back('{w: 2'd0, pc: 8'h40});
      for (int k = 0; k < 4; k++) sb.push_back('{w: 2'd2, pc: 8'(8'h40 + k)});
      launch(4'b0101, 8'h40);
      run(40, "mem");
      repeat (3) @(negedge clk);
      check("mem_hold_valid", 32'(bus.issue_valid), 32'd1);
      check("mem_hold_warp",  32'(bus.issue_warp),  32'd2);
      check("mem_hold_pc",    32'(bus.issue_pc),    32'h44);
      @(posedge clk); #1;
      bus.mem_done_valid = 1'b1;
      bus.mem_done_warp  = 2'd0;
      @(posedge clk); #1;
      bus.mem_done_valid = 1'b0;
      @(negedge clk);
      check("mem_hold2_warp", 32'(bus.issue_warp), 32'd2);
      @(posedge clk); #1;
      sb.push_back('{w: 2'd2, pc: 8'h44});
      sb.push_back('{w: 2'd0, pc: 8'h41});
      sb.push_back('{w: 2'd2, pc: 8'h45});
      run(20, "memdone");

      // both warps halt; FINISH ignores spurious reports and empty launches
      do_reset();
      halt_on = 4'b0011;
      sb.push_back('{w: 2'd0, pc: 8'h50});
      sb.push_back('{w: 2'd1, pc: 8'h50});
      launch(4'b0011, 8'h50);
      run(20, "halt");
      @(negedge clk);
      check("fin_done",  32'(bus.kernel_done), 32'd1);
      check("fin_busy",  32'(bus.busy),        32'd0);
      check("fin_valid", 32'(bus.issue_valid), 32'd0);
      @(posedge clk); #1;
      bus.retire_valid   = 1'b1;
      bus.retire_warp    = 2'd0;
      bus.retire_next_pc = 8'h99;
      bus.mem_done_valid = 1'b1;
      bus.mem_done_warp  = 2'd1;
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check("spur_done",  32'(bus.kernel_done), 32'd1);
      check("spur_valid", 32'(bus.issue_valid), 32'd0);
`ifdef WARP_SCHED_STALL_CNT_EN
      s_ref = stall;
      @(negedge clk);
      check("fin_stall_hold", 32'(stall), 32'(s_ref));
`endif
      launch(4'b0000, 8'h66);
      @(negedge clk);
      check("zero_mask_done", 32'(bus.kernel_done), 32'd1);
      check("zero_mask_busy", 32'(bus.busy),        32'd0);

      // relaunch from FINISH, then hold the offer for five stalled cycles
      launch(4'b0010, 8'h22);
      @(negedge clk);
      check("re_busy", 32'(bus.busy),        32'd1);
      check("re_done", 32'(bus.kernel_done), 32'd0);
      @(negedge clk);
      check("st_valid0", 32'(bus.issue_valid), 32'd1);
      check("st_warp0",  32'(bus.issue_warp),  32'd1);
      check("st_pc0",    32'(bus.issue_pc),    32'h22);
`ifdef WARP_SCHED_STALL_CNT_EN
      check("st_stall_clear", 32'(stall), 32'd1);
      s_ref = stall;
`endif
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 2) begin
            bus.warp_mask = 4'b1111;
            bus.start_pc  = 8'h77;
            bus.start     = 1'b1;
         end else begin
            bus.start     = 1'b0;
         end
         @(negedge clk);
         check($sformatf("st_valid%0d", c), 32'(bus.issue_valid), 32'd1);
         check($sformatf("st_warp%0d", c),  32'(bus.issue_warp),  32'd1);
         check($sformatf("st_pc%0d", c),    32'(bus.issue_pc),    32'h22);
      end
`ifdef WARP_SCHED_STALL_CNT_EN
      check("st_stall_plus5", 32'(stall), 32'(s_ref + 16'd5));
`endif

      // reset in the middle of a kernel, then a clean restart
      do_reset();
      mem_once = 4'b0010;
      sb.push_back('{w: 2'd0, pc: 8'h30});
      sb.push_back('{w: 2'd1, pc: 8'h30});
      sb.push_back('{w: 2'd2, pc: 8'h30});
      launch(4'b1111, 8'h30);
      run(30, "pre_rst");
      reset = 1'b1;
      #1;
      check("arst_valid", 32'(bus.issue_valid), 32'd0);
      check("arst_warp",  32'(bus.issue_warp),  32'd0);
      check("arst_pc",    32'(bus.issue_pc),    32'd0);
      check("arst_busy",  32'(bus.busy),        32'd0);
      check("arst_done",  32'(bus.kernel_done), 32'd0);
`ifdef WARP_SCHED_STALL_CNT_EN
      check("arst_stall", 32'(stall), 32'd0);
`endif
      clear_inputs();
      mem_once = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_rst_valid", 32'(bus.issue_valid), 32'd0);
      check("post_rst_busy",  32'(bus.busy),        32'd0);
      sb.push_back('{w: 2'd0, pc: 8'h31});
      sb.push_back('{w: 2'd1, pc: 8'h31});
      sb.push_back('{w: 2'd2, pc: 8'h31});
      launch(4'b1111, 8'h31);
      run(30, "restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
